// File: rtl/router_sw_alloc_pkg.sv
// Shared constants for the 5-port mesh router switch allocator: port indices,
// route-computation output codes and small index helpers.
package router_sw_alloc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int IDX_W     = 3;

    typedef enum logic [IDX_W-1:0] {
        PORT_LOCAL = 3'd0,
        PORT_X1    = 3'd1,
        PORT_X2    = 3'd2,
        PORT_Y1    = 3'd3,
        PORT_Y2    = 3'd4
    } port_idx_e;

    // Codes produced by route computation; 3'd6 and 3'd7 are unused.
    typedef enum logic [IDX_W-1:0] {
        EMPTY          = 3'd0,
        OUT_LOCAL_PORT = 3'd1,
        OUT_X1_PORT    = 3'd2,
        OUT_X2_PORT    = 3'd3,
        OUT_Y1_PORT    = 3'd4,
        OUT_Y2_PORT    = 3'd5
    } port_code_e;

    function automatic logic [NUM_PORTS-1:0] decode_port(input logic [IDX_W-1:0] code);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        case (code)
            EMPTY:          oh = '0;
            OUT_LOCAL_PORT: oh[PORT_LOCAL] = 1'b1;
            OUT_X1_PORT:    oh[PORT_X1]    = 1'b1;
            OUT_X2_PORT:    oh[PORT_X2]    = 1'b1;
            OUT_Y1_PORT:    oh[PORT_Y1]    = 1'b1;
            OUT_Y2_PORT:    oh[PORT_Y2]    = 1'b1;
            default:        oh = '0;
        endcase
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx >= IDX_W'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/router_sw_alloc_rr_arbiter.sv
// Round-robin pick among 5 requesters starting at ptr; purely combinational, zero latency.
// No backpressure handling here: the caller gates the pick with downstream credit.
module rr_arbiter
    import router_sw_alloc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = (ptr < IDX_W'(NUM_PORTS)) ? ptr : '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/router_sw_alloc.sv
// Wormhole switch allocator for a 5-port router; zero-cycle grant, one input per output.
// Backpressure: an output without out_ready fires nothing and keeps its pointer, lock and owner.
module router_sw_alloc
    import router_sw_alloc_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PORTS-1:0]       in_valid,
    input  logic [NUM_PORTS*IDX_W-1:0] in_port,
    input  logic [NUM_PORTS-1:0]       in_tail,
    input  logic [NUM_PORTS-1:0]       out_ready,
    output logic [NUM_PORTS-1:0]       grant,
    output logic [NUM_PORTS-1:0]       out_fire,
    output logic [NUM_PORTS*IDX_W-1:0] out_sel,
    output logic [NUM_PORTS-1:0]       out_locked
);

    logic [NUM_PORTS-1:0] dest     [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_out  [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_gnt  [NUM_PORTS];
    logic [IDX_W-1:0]     arb_idx  [NUM_PORTS];
    logic [NUM_PORTS-1:0] win_oh   [NUM_PORTS];
    logic [IDX_W-1:0]     win_idx  [NUM_PORTS];
    logic [IDX_W-1:0]     ptr_q    [NUM_PORTS];
    logic [IDX_W-1:0]     owner_q  [NUM_PORTS];
    logic [NUM_PORTS-1:0] locked_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dec
        assign dest[i] = in_valid[i] ? decode_port(in_port[i*IDX_W +: IDX_W]) : '0;
    end

    // Transpose per-input destinations into per-output request vectors.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            req_out[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_out[o][i] = dest[i][o];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter u_arb (
            .req     (req_out[o]),
            .ptr     (ptr_q[o]),
            .gnt     (arb_gnt[o]),
            .gnt_idx (arb_idx[o])
        );
    end

    // A locked output only considers its owner; an owner that stops requesting it is a bubble.
    always_comb begin
        grant    = '0;
        out_fire = '0;
        out_sel  = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (locked_q[o]) begin
                win_oh[o]  = req_out[o] & (NUM_PORTS'(1) << owner_q[o]);
                win_idx[o] = owner_q[o];
            end else begin
                win_oh[o]  = arb_gnt[o];
                win_idx[o] = arb_idx[o];
            end
            if (out_ready[o] && (|win_oh[o])) begin
                out_fire[o]                = 1'b1;
                out_sel[o*IDX_W +: IDX_W]  = win_idx[o];
                grant                      = grant | win_oh[o];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                ptr_q[o]   <= '0;
                owner_q[o] <= '0;
            end
            locked_q <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (out_fire[o]) begin
                    ptr_q[o] <= next_idx(win_idx[o]);
                    if (in_tail[win_idx[o]]) begin
                        locked_q[o] <= 1'b0;
                    end else begin
                        locked_q[o] <= 1'b1;
                        owner_q[o]  <= win_idx[o];
                    end
                end
            end
        end
    end

    assign out_locked = locked_q;

endmodule

// File: tb/tb_router_sw_alloc.sv
// Bench for router_sw_alloc: each cycle's expected grant/fire/sel/lock is queued at drive
// time and popped when the combinational outputs are sampled on the falling edge.
module tb_router_sw_alloc;
    import router_sw_alloc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  in_valid;
    logic [14:0] in_port;
    logic [4:0]  in_tail;
    logic [4:0]  out_ready;
    logic [4:0]  grant;
    logic [4:0]  out_fire;
    logic [14:0] out_sel;
    logic [4:0]  out_locked;

    typedef struct {
        logic [4:0]  grant;
        logic [4:0]  fire;
        logic [14:0] sel;
        logic [4:0]  locked;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [2:0] c_e, c_l, c_x1, c_x2, c_y1, c_y2;

    router_sw_alloc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_port    (in_port),
        .in_tail    (in_tail),
        .out_ready  (out_ready),
        .grant      (grant),
        .out_fire   (out_fire),
        .out_sel    (out_sel),
        .out_locked (out_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [14:0] pk(input logic [2:0] f0, input logic [2:0] f1,
                                       input logic [2:0] f2, input logic [2:0] f3,
                                       input logic [2:0] f4);
        return {f4, f3, f2, f1, f0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: output sampled with no expectation queued");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".grant"},  32'(grant),      32'(e.grant));
            check({t, ".fire"},   32'(out_fire),   32'(e.fire));
            check({t, ".sel"},    32'(out_sel),    32'(e.sel));
            check({t, ".locked"}, 32'(out_locked), 32'(e.locked));
        end
    endtask

    task automatic step(input string tag, input logic [4:0] v, input logic [14:0] p,
                        input logic [4:0] t, input logic [4:0] r,
                        input logic [4:0] eg, input logic [4:0] ef,
                        input logic [14:0] es, input logic [4:0] el);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_port   = p;
        in_tail   = t;
        out_ready = r;
        e.grant  = eg;
        e.fire   = ef;
        e.sel    = es;
        e.locked = el;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        compare_out();
    endtask

    initial begin
        c_e  = EMPTY;
        c_l  = OUT_LOCAL_PORT;
        c_x1 = OUT_X1_PORT;
        c_x2 = OUT_X2_PORT;
        c_y1 = OUT_Y1_PORT;
        c_y2 = OUT_Y2_PORT;

        rst_n     = 1'b0;
        in_valid  = '0;
        in_port   = '0;
        in_tail   = '0;
        out_ready = '0;
        step("reset", 5'b0, 15'b0, 5'b0, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b0);
        rst_n = 1'b1;

        // Single-flit packet, input 0 to X2
        step("t1_fire", 5'b00001, pk(c_x2, c_e, c_e, c_e, c_e), 5'b00001, 5'b11111,
             5'b00001, 5'b00100, 15'b0, 5'b0);
        step("t1_idle", 5'b0, 15'b0, 5'b0, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b0);

        // Round-robin on LOCAL, including wrap from pointer 4 to input 0
        step("t2_rr_a", 5'b01010, pk(c_e, c_l, c_e, c_l, c_e), 5'b11111, 5'b11111,
             5'b00010, 5'b00001, pk(3'd1, 3'd0, 3'd0, 3'd0, 3'd0), 5'b0);
        step("t2_rr_b", 5'b01000, pk(c_e, c_l, c_e, c_l, c_e), 5'b11111, 5'b11111,
             5'b01000, 5'b00001, pk(3'd3, 3'd0, 3'd0, 3'd0, 3'd0), 5'b0);
        step("t2_wrap", 5'b01001, pk(c_l, c_e, c_e, c_l, c_e), 5'b11111, 5'b11111,
             5'b00001, 5'b00001, 15'b0, 5'b0);

        // Empty and undefined codes never request
        step("undef", 5'b00111, pk(3'd7, c_e, 3'd6, c_e, c_e), 5'b11111, 5'b11111,
             5'b0, 5'b0, 15'b0, 5'b0);

        // Wormhole: input 2 holds Y1 from head to tail while input 0 waits
        step("t3_head", 5'b00100, pk(c_e, c_e, c_y1, c_e, c_e), 5'b00000, 5'b11111,
             5'b00100, 5'b01000, pk(3'd0, 3'd0, 3'd0, 3'd2, 3'd0), 5'b0);
        step("t3_body1", 5'b00101, pk(c_y1, c_e, c_y1, c_e, c_e), 5'b00001, 5'b11111,
             5'b00100, 5'b01000, pk(3'd0, 3'd0, 3'd0, 3'd2, 3'd0), 5'b01000);
        step("t3_body2", 5'b00101, pk(c_y1, c_e, c_y1, c_e, c_e), 5'b00001, 5'b11111,
             5'b00100, 5'b01000, pk(3'd0, 3'd0, 3'd0, 3'd2, 3'd0), 5'b01000);
        step("t3_tail", 5'b00101, pk(c_y1, c_e, c_y1, c_e, c_e), 5'b00101, 5'b11111,
             5'b00100, 5'b01000, pk(3'd0, 3'd0, 3'd0, 3'd2, 3'd0), 5'b01000);
        step("t3_after", 5'b00001, pk(c_y1, c_e, c_e, c_e, c_e), 5'b00001, 5'b11111,
             5'b00001, 5'b01000, 15'b0, 5'b0);

        // Backpressure on Y1 for three cycles, then credit returns
        for (int k = 0; k < 3; k++) begin
            step("t4_stall", 5'b10000, pk(c_e, c_e, c_e, c_e, c_y1), 5'b10000, 5'b10111,
                 5'b0, 5'b0, 15'b0, 5'b0);
        end
        step("t4_go", 5'b10000, pk(c_e, c_e, c_e, c_e, c_y1), 5'b10000, 5'b11111,
             5'b10000, 5'b01000, pk(3'd0, 3'd0, 3'd0, 3'd4, 3'd0), 5'b0);

        // Lock X1 to input 3, bubble with another requester blocked, then reset mid-packet
        step("t5_head", 5'b01000, pk(c_e, c_e, c_e, c_x1, c_e), 5'b00000, 5'b11111,
             5'b01000, 5'b00010, pk(3'd0, 3'd3, 3'd0, 3'd0, 3'd0), 5'b0);
        step("t5_blocked", 5'b00010, pk(c_e, c_x1, c_e, c_e, c_e), 5'b00010, 5'b11111,
             5'b0, 5'b0, 15'b0, 5'b00010);
        rst_n = 1'b0;
        step("t5_rst", 5'b0, 15'b0, 5'b0, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b0);
        rst_n = 1'b1;
        step("t5_new_head", 5'b00010, pk(c_e, c_x1, c_e, c_e, c_e), 5'b00000, 5'b11111,
             5'b00010, 5'b00010, pk(3'd0, 3'd1, 3'd0, 3'd0, 3'd0), 5'b0);
        step("t5_other_blk", 5'b01000, pk(c_e, c_e, c_e, c_x1, c_e), 5'b01000, 5'b11111,
             5'b0, 5'b0, 15'b0, 5'b00010);
        step("t5_tail", 5'b00010, pk(c_e, c_x1, c_e, c_e, c_e), 5'b00010, 5'b11111,
             5'b00010, 5'b00010, pk(3'd0, 3'd1, 3'd0, 3'd0, 3'd0), 5'b00010);

        // All five outputs allocated in one cycle
        step("t6_full", 5'b11111, pk(c_y2, c_y1, c_l, c_x2, c_x1), 5'b11111, 5'b11111,
             5'b11111, 5'b11111, pk(3'd2, 3'd4, 3'd3, 3'd1, 3'd0), 5'b0);
        step("t6_idle", 5'b0, 15'b0, 5'b0, 5'b11111, 5'b0, 5'b0, 15'b0, 5'b0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_sw_alloc.md
Name: router_sw_alloc

Overview:
Switch allocator for one 5-port mesh router, directly downstream of the per-input route-computation stage. Each input presents a valid flit and the 3-bit output-port code computed for its packet. The allocator grants at most one input per output with round-robin fairness. It holds an output for one input from head flit to tail flit (wormhole), and drives crossbar select and fire signals.

Parameters:
NUM_PORTS, 5, number of input and output ports; index 0=LOCAL, 1=X1, 2=X2, 3=Y1, 4=Y2.
IDX_W, 3, width of an input index on out_sel.

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  5  flit present at input i.
in_port  input  15  output-port code for input i, bits [3i+2:3i]; codes are the global.v defines EMPTY, OUT_LOCAL_PORT, OUT_X1_PORT, OUT_X2_PORT, OUT_Y1_PORT, OUT_Y2_PORT.
in_tail  input  5  flit at input i is the packet's tail; a single-flit packet has tail=1.
out_ready  input  5  downstream credit available on output o.
grant  output  5  input i's flit transfers this cycle.
out_fire  output  5  output o carries a flit this cycle.
out_sel  output  15  input index driving output o, bits [3o+2:3o]; 3'd0 when not firing.
out_locked  output  5  output o is held by an in-progress packet (registered state).

Behaviour:
- Reset is asynchronous, active-low; clock is clk. On reset: all locks cleared, owner indices 0, all RR pointers 0.
- grant, out_fire and out_sel are combinational from the inputs and registered state. With in_valid=0 they are all 0. out_locked resets to 0.
- Request decoding:
  - input i requests output o iff in_valid[i]=1 and in_port[i] decodes to o.
  - EMPTY and any undefined code never request anything.
- Free output o (out_locked[o]=0):
  - Candidates are the requesters of o.
  - Winner is the first candidate found searching i = ptr[o], ptr[o]+1, ... mod 5.
  - Fire only if out_ready[o]=1.
- Locked output o:
  - Only owner[o] may fire, and only if it is requesting o and out_ready[o]=1.
  - Other requesters of o are blocked (no grant).
- grant[i]=1 iff input i fires on its requested output. At most one grant per input and one per output.
- On fire of output o by input w, at the clock edge:
  - ptr[o] <= (w+1) mod 5.
  - If in_tail[w]=1: out_locked[o] <= 0.
  - Otherwise: out_locked[o] <= 1 and owner[o] <= w.
  - A head flit that is also a tail never locks.
- No fire on output o: ptr, lock and owner for o are unchanged. This covers backpressure (out_ready=0) and an idle owner (bubble inside a packet).
- Latency: zero-cycle grant. The upstream stage must hold in_valid, in_port and in_tail stable until granted.
- Distinct outputs are allocated independently; up to 5 grants in one cycle.
- U-turn codes (input i requesting its own direction) are not filtered.
- Owner changing in_port mid-packet is a protocol violation. The owner is simply not granted on its locked output, and the lock is retained.
- Reset asserted mid-packet drops all locks immediately. Upstream buffers are reset with the same rst_n.

Decomposition:
- global.v holds the port-code defines (EMPTY, OUT_*_PORT), the port-index defines (LOCAL=0..Y2=4), and NUM_PORTS.
- One sub-module, rr_arbiter: 5 request bits plus a 3-bit pointer in, one-hot grant and encoded index out.
  - Purely combinational.
  - Instantiated once per output; pointers and locks live in router_sw_alloc.

Test Plan:
1. After reset, in_valid=5'b00001, in_port[0]=OUT_X2_PORT, in_tail[0]=1, out_ready=5'b11111 -> grant=5'b00001, out_fire=5'b00100, out_sel[X2]=0; next cycle out_locked=0 and ptr[X2]=1.
2. Inputs 1 and 3 both request OUT_LOCAL_PORT with tail=1 and ptr=0 -> cycle 1 grant=5'b00010; input 1 drops, input 3 held -> cycle 2 grant=5'b01000. Then inputs 0 and 3 both request OUT_LOCAL_PORT with ptr[LOCAL]=4 -> input 0 wins (wrap-around).
3. Wormhole:
   - Input 2 head (tail=0) to OUT_Y1_PORT fires -> out_locked[Y1]=1.
   - Input 0 requests OUT_Y1_PORT for 3 cycles while input 2 sends body, body, tail -> only grant[2] asserted.
   - Cycle after the tail -> out_locked[Y1]=0 and grant[0]=1.
4. out_ready[Y1]=0 with input 4 requesting OUT_Y1_PORT -> grant=0, out_fire=0, state unchanged for 3 cycles; raise out_ready[Y1] -> grant[4]=1 in that same cycle.
5. Lock output X1 to input 3 (head, tail=0), then pulse rst_n low for one cycle -> out_locked=0, all outputs 0. Afterwards input 1 head to OUT_X1_PORT is granted immediately.
6. Inputs 0..4 request Y2, Y1, LOCAL, X2, X1 respectively, all ready -> grant=5'b11111, out_fire=5'b11111, out_sel = {0,1,2,3,4} per respective output.
